// File: rtl/ctrl_pkg.sv
// Shared constants for the CPU-side controller port: default base address,
// read-data field layout and the pad-count limit.
package ctrl_pkg;

  localparam logic [15:0] CTRL_BASE_DEFAULT = 16'h4016;
  localparam int          CTRL_MAX_PORTS    = 8;

  // data_o layout: D0 serial bit, D4:D1 forced zero, D7:D5 open bus
  localparam int          D_SERIAL_BIT  = 0;
  localparam int          D_ZERO_LSB    = 1;
  localparam int          D_ZERO_MSB    = 4;
  localparam logic [7:0]  OPEN_BUS_MASK = 8'hE0;

  function automatic logic [7:0] read_word(input logic [7:0] bus, input logic bitval);
    logic [7:0] w;
    w = bus & OPEN_BUS_MASK;
    w[D_ZERO_MSB:D_ZERO_LSB] = '0;
    w[D_SERIAL_BIT] = bitval;
    return w;
  endfunction

endpackage

// File: rtl/ctrl_shift_chain.sv
// One serial report chain: parallel load from synchronised pad state, shift
// right on read with ones filling in from the top so an exhausted chain reads 1.
module ctrl_shift_chain #(
  parameter int L = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [L-1:0] par_i,
  output logic         bit0_o
);

  logic [L-1:0] chain_q;
  logic [L-1:0] chain_d;

  always_comb begin
    chain_d = chain_q;
    if (load_i) begin
      chain_d = par_i;
    end else if (shift_i) begin
      chain_d = {1'b1, chain_q[L-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain_q <= '1;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign bit0_o = chain_q[0];

endmodule

// File: rtl/ctrl_port_if.sv
// CPU-side controller port: strobe register at BASE_ADDR, serial reads of
// daisy-chained pads at BASE_ADDR (even pads) and BASE_ADDR+1 (odd pads).
module ctrl_port_if
  import ctrl_pkg::*;
#(
  parameter int          NUM_PORTS   = 2,
  parameter int          REPORT_BITS = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] BASE_ADDR   = CTRL_BASE_DEFAULT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cpu_ce,
  input  logic [15:0]                      addr_i,
  input  logic                             rw_i,
  input  logic [7:0]                       data_i,
  input  logic [7:0]                       bus_data_i,
  input  logic [NUM_PORTS*REPORT_BITS-1:0] pad_state_i,
  output logic [2:0]                       strobe_o,
  output logic [1:0]                       read_pulse_o,
  output logic                             cs_o,
  output logic [7:0]                       data_o
);

  localparam int          PW      = NUM_PORTS * REPORT_BITS;
  localparam int          L       = PW / 2;
  localparam logic [15:0] ADDR_LO = BASE_ADDR;
  localparam logic [15:0] ADDR_HI = BASE_ADDR + 16'd1;

  if (NUM_PORTS < 2 || NUM_PORTS > CTRL_MAX_PORTS || (NUM_PORTS % 2) != 0) begin : g_bad_ports
    $error("ctrl_port_if: NUM_PORTS must be even and in 2..%0d", CTRL_MAX_PORTS);
  end
  if (SYNC_STAGES < 1 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("ctrl_port_if: SYNC_STAGES must be in 1..3");
  end

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] pad_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pad_state_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign pad_s = sync_q[SYNC_STAGES-1];

  logic [2:0] strobe_q, strobe_d;
  logic [1:0] pulse_q, pulse_d;
  logic       cs_q, cs_d;
  logic [7:0] data_q, data_d;
  logic [1:0] rd_hit;
  logic [1:0] shift;
  logic [1:0] chain_bit;
  logic       wr_hit;
  logic       load;
  logic       bitval;
  logic       data_unused;

  assign data_unused = ^data_i[7:3];

  assign wr_hit    = cpu_ce && !rw_i && (addr_i == ADDR_LO);
  assign rd_hit[0] = cpu_ce && rw_i && (addr_i == ADDR_LO);
  assign rd_hit[1] = cpu_ce && rw_i && (addr_i == ADDR_HI);
  // While strobe is high the chains reload every bus cycle, so reads never shift.
  assign load      = cpu_ce && strobe_q[0];
  assign shift     = rd_hit & {2{~strobe_q[0]}};

  for (genvar a = 0; a < 2; a++) begin : g_chain
    logic [L-1:0] par;
    for (genvar k = 0; k < NUM_PORTS / 2; k++) begin : g_pad
      assign par[k*REPORT_BITS +: REPORT_BITS] = pad_s[(a + 2*k)*REPORT_BITS +: REPORT_BITS];
    end
    ctrl_shift_chain #(.L(L)) u_chain (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load),
      .shift_i (shift[a]),
      .par_i   (par),
      .bit0_o  (chain_bit[a])
    );
  end

  always_comb begin
    bitval = 1'b1;
    if (rd_hit[1]) begin
      bitval = strobe_q[0] ? pad_s[REPORT_BITS] : chain_bit[1];
    end else begin
      bitval = strobe_q[0] ? pad_s[0] : chain_bit[0];
    end
    strobe_d = wr_hit ? data_i[2:0] : strobe_q;
    pulse_d  = rd_hit;
    cs_d     = |rd_hit;
    data_d   = (|rd_hit) ? read_word(bus_data_i, bitval) : 8'h00;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      strobe_q <= '0;
      pulse_q  <= '0;
      cs_q     <= 1'b0;
      data_q   <= '0;
    end else begin
      strobe_q <= strobe_d;
      pulse_q  <= pulse_d;
      cs_q     <= cs_d;
      data_q   <= data_d;
    end
  end

  assign strobe_o     = strobe_q;
  assign read_pulse_o = pulse_q;
  assign cs_o         = cs_q;
  assign data_o       = data_q;

endmodule

// File: tb/tb_ctrl_port_if.sv
// Bench for ctrl_port_if (four pads): queue-based reference model checked on
// every cycle, plus literal expectations for the documented scenarios.
module tb_ctrl_port_if;

  localparam int          NP   = 4;
  localparam int          RB   = 8;
  localparam int          SYNC = 2;
  localparam int          W    = NP * RB;
  localparam logic [15:0] BASE = 16'h4016;

  // ---------------- clock / reset ----------------
  logic          clk;
  logic          rst;
  logic          cpu_ce;
  logic [15:0]   addr_i;
  logic          rw_i;
  logic [7:0]    data_i;
  logic [7:0]    bus_data_i;
  logic [W-1:0]  pad_state_i;
  logic [2:0]    strobe_o;
  logic [1:0]    read_pulse_o;
  logic          cs_o;
  logic [7:0]    data_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ctrl_port_if #(
    .NUM_PORTS   (NP),
    .REPORT_BITS (RB),
    .SYNC_STAGES (SYNC),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_ce       (cpu_ce),
    .addr_i       (addr_i),
    .rw_i         (rw_i),
    .data_i       (data_i),
    .bus_data_i   (bus_data_i),
    .pad_state_i  (pad_state_i),
    .strobe_o     (strobe_o),
    .read_pulse_o (read_pulse_o),
    .cs_o         (cs_o),
    .data_o       (data_o)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Each chain is the list of bits still to be reported; an empty list reads 1.
  bit           ch0_q[$];
  bit           ch1_q[$];
  logic [W-1:0] sync_m [SYNC];
  logic [W-1:0] m_ps;
  logic [2:0]   m_nstb;
  logic         m_b;
  int           m_a;
  logic         exp_cs;
  logic [1:0]   exp_pulse;
  logic [7:0]   exp_data;
  logic [2:0]   exp_strobe;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_cs = 1'b0; exp_pulse = '0; exp_data = '0; exp_strobe = '0;
      ch0_q.delete(); ch1_q.delete();
      for (int i = 0; i < SYNC; i++) sync_m[i] = '0;
    end else begin
      m_ps = sync_m[SYNC-1];
      m_nstb = exp_strobe;
      exp_cs = 1'b0; exp_pulse = '0; exp_data = '0;
      if (cpu_ce) begin
        if (!rw_i && addr_i == BASE) m_nstb = data_i[2:0];
        if (rw_i && (addr_i == BASE || addr_i == BASE + 16'd1)) begin
          m_a = (addr_i == BASE) ? 0 : 1;
          if (exp_strobe[0]) m_b = m_ps[m_a*RB];
          else if (m_a == 0) m_b = (ch0_q.size() > 0) ? ch0_q.pop_front() : 1'b1;
          else               m_b = (ch1_q.size() > 0) ? ch1_q.pop_front() : 1'b1;
          exp_cs = 1'b1;
          exp_pulse[m_a] = 1'b1;
          exp_data = {bus_data_i[7:5], 4'b0000, m_b};
        end
        if (exp_strobe[0]) begin
          ch0_q.delete(); ch1_q.delete();
          for (int p = 0; p < NP; p++)
            for (int k = 0; k < RB; k++)
              if (p % 2 == 0) ch0_q.push_back(m_ps[p*RB + k]);
              else            ch1_q.push_back(m_ps[p*RB + k]);
        end
      end
      for (int i = SYNC - 1; i > 0; i--) sync_m[i] = sync_m[i-1];
      sync_m[0] = pad_state_i;
      exp_strobe = m_nstb;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("cs_o",         32'(cs_o),         32'(exp_cs));
      check("read_pulse_o", 32'(read_pulse_o), 32'(exp_pulse));
      check("data_o",       32'(data_o),       32'(exp_data));
      check("strobe_o",     32'(strobe_o),     32'(exp_strobe));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_op(input logic ce, input logic rw, input logic [15:0] a, input logic [7:0] d);
    cpu_ce = ce; rw_i = rw; addr_i = a; data_i = d;
    @(posedge clk); #2;
    cpu_ce = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic d0);
    bus_op(1'b1, 1'b1, a, 8'h00);
    d0 = data_o[0];
  endtask

  task automatic idle(input int n);
    repeat (n) bus_op(1'b0, 1'b1, 16'h0000, 8'h00);
  endtask

  task automatic strobe_pulse();
    bus_op(1'b1, 1'b0, BASE, 8'h01);
    bus_op(1'b1, 1'b0, BASE, 8'h00);
  endtask

  // ---------------- stimulus ----------------
  logic [16:0] got0, got1;
  logic        b;
  logic [7:0]  rdat;

  initial begin
    rst = 1'b1; cpu_ce = 1'b0; addr_i = '0; rw_i = 1'b1; data_i = '0;
    bus_data_i = 8'hA0; pad_state_i = '0;
    #3 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 chk_en = 1'b1;
    check("reset strobe_o", 32'(strobe_o), 32'h0);
    check("reset cs_o", 32'(cs_o), 32'h0);
    rst = 1'b1;

    // first read after reset: exhausted chain, open bus on top
    bus_op(1'b1, 1'b1, BASE, 8'h00);
    check("first read data_o", 32'(data_o), 32'hA1);
    check("first read pulse", 32'(read_pulse_o), 32'h1);

    // serial sequence of pad0 followed by pad2
    pad_state_i = 32'h00_FF_02_05;
    idle(3);
    strobe_pulse();
    got0 = '0;
    for (int i = 0; i < 9; i++) begin rd(BASE, b); got0[i] = b; end
    check("pad0 sequence", 32'(got0[8:0]), 32'h105);
    rd(BASE + 16'd1, b); check("pad1 bit0 untouched", 32'(b), 32'h0);
    rd(BASE + 16'd1, b); check("pad1 bit1", 32'(b), 32'h1);

    // strobe held: live bit0, no shifting
    bus_op(1'b1, 1'b0, BASE, 8'h01);
    got0 = '0;
    for (int i = 0; i < 3; i++) begin rd(BASE, b); got0[i] = b; end
    check("strobe held reads", 32'(got0[2:0]), 32'h7);
    pad_state_i[0] = 1'b0;
    idle(SYNC);
    rd(BASE, b); check("live bit0 after sync", 32'(b), 32'h0);
    bus_op(1'b1, 1'b0, BASE, 8'h00);

    // strobe register decode
    bus_op(1'b1, 1'b0, BASE, 8'h05);
    check("strobe write", 32'(strobe_o), 32'h5);
    bus_op(1'b1, 1'b0, BASE + 16'd1, 8'h02);
    check("write odd addr ignored", 32'(strobe_o), 32'h5);
    bus_op(1'b0, 1'b0, BASE, 8'h03);
    check("write without ce ignored", 32'(strobe_o), 32'h5);
    bus_op(1'b1, 1'b0, BASE, 8'h00);

    // four pads daisy-chained across both addresses
    pad_state_i = 32'hF0_00_0F_FF;
    idle(3);
    strobe_pulse();
    for (int i = 0; i < 17; i++) begin rd(BASE, b); got0[i] = b; end
    for (int i = 0; i < 17; i++) begin rd(BASE + 16'd1, b); got1[i] = b; end
    check("4016 chain", 32'(got0), 32'h100FF);
    check("4017 chain", 32'(got1), 32'h1F00F);

    // reset in the middle of a read sequence
    pad_state_i = '0;
    idle(3);
    strobe_pulse();
    for (int i = 0; i < 3; i++) rd(BASE, b);
    check("pre-reset read", 32'(data_o), 32'hA0);
    bus_op(1'b1, 1'b1, BASE, 8'h00);
    #1 rst = 1'b0;
    #1;
    check("async reset cs_o", 32'(cs_o), 32'h0);
    check("async reset data_o", 32'(data_o), 32'h0);
    check("async reset pulse", 32'(read_pulse_o), 32'h0);
    @(posedge clk); #2 rst = 1'b1;
    rd(BASE, b);          check("post-reset 4016", 32'(b), 32'h1);
    rd(BASE + 16'd1, b);  check("post-reset 4017", 32'(b), 32'h1);

    // randomized traffic against the model
    for (int it = 0; it < 1200; it++) begin
      logic [15:0] a;
      logic [7:0]  d;
      if ($urandom_range(0, 39) == 0) pad_state_i = $urandom;
      bus_data_i = 8'($urandom);
      case ($urandom_range(0, 5))
        0, 1:    a = BASE;
        2, 3:    a = BASE + 16'd1;
        4:       a = BASE + 16'd2;
        default: a = 16'($urandom);
      endcase
      d = 8'($urandom);
      if ($urandom_range(0, 3) != 0) d[0] = 1'b0;
      if (it == 600) begin
        rst = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
      end
      bus_op($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, a, d);
      rdat = data_o;
    end

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
